// File: rtl/handshake_fifo.sv
// Elastic req/ack buffer between an upstream producer and a downstream operator.
// Ports: clk/rst, up_req/up_ack/up_din, dn_req/dn_ack/dn_dout, level, count_in/out, overflow.
module handshake_fifo #(
  parameter int data_width = 32,
  parameter int depth      = 4,
  parameter int fifo_id    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         up_req,
  input  logic                         up_ack,
  input  logic [data_width-1:0]        up_din,
  input  logic                         dn_req,
  output logic                         dn_ack,
  output logic [data_width-1:0]        dn_dout,
  output logic [$clog2(depth+1)-1:0]   level,
  output logic [31:0]                  count_in,
  output logic [31:0]                  count_out,
  output logic                         overflow
);

  localparam int AW = $clog2(depth);
  localparam int LW = $clog2(depth + 1);

  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("handshake_fifo %0d: depth must be a power of two >= 2", fifo_id);
  end

  logic [data_width-1:0] mem [depth];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  outstanding;
  logic                  req_next;
  logic [LW-1:0]         level_next;

  always_comb begin
    full        = (level == LW'(depth));
    pop         = dn_req & ~dn_ack & (level != '0);
    // a pop frees the slot the simultaneous push lands in
    push        = up_ack & (~full | pop);
    drop        = up_ack & full & ~pop;
    // an ack may still arrive for the request currently shown
    outstanding = up_req & ~up_ack;
    level_next  = level + LW'(push) - LW'(pop);
    req_next    = (depth - int'(level_next)) > int'(outstanding);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= up_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_req    <= 1'b0;
      dn_ack    <= 1'b0;
      dn_dout   <= '0;
      level     <= '0;
      count_in  <= '0;
      count_out <= '0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      up_req <= req_next;
      dn_ack <= pop;
      level  <= level_next;
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        count_in <= count_in + 32'd1;
      end
      if (pop) begin
        dn_dout   <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
        count_out <= count_out + 32'd1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_handshake_fifo.sv
// Randomized scoreboard bench for handshake_fifo.
// Queue-level model predicts tokens, occupancy, acks, counters and overflow.
module tb_handshake_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          up_req;
  logic          up_ack = 1'b0;
  logic [DW-1:0] up_din = '0;
  logic          dn_req = 1'b0;
  logic          dn_ack;
  logic [DW-1:0] dn_dout;
  logic [LW-1:0] level;
  logic [31:0]   count_in;
  logic [31:0]   count_out;
  logic          overflow;

  handshake_fifo #(.data_width(DW), .depth(DEPTH), .fifo_id(7)) dut (
    .clk(clk), .rst(rst),
    .up_req(up_req), .up_ack(up_ack), .up_din(up_din),
    .dn_req(dn_req), .dn_ack(dn_ack), .dn_dout(dn_dout),
    .level(level), .count_in(count_in), .count_out(count_out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: token queue plus bookkeeping
  logic [DW-1:0] sb[$];
  int   m_cnt  = 0;
  bit   m_ack  = 0;
  bit   m_req  = 0;
  bit   m_ovf  = 0;
  int   m_cin  = 0;
  int   m_cout = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      sb.delete();
      m_cnt = 0; m_ack = 0; m_req = 0;
      m_ovf = 0; m_cin = 0; m_cout = 0;
    end else begin
      bit p, a, outst;
      p = dn_req && !m_ack && (m_cnt > 0);
      a = up_ack && ((m_cnt < DEPTH) || p);
      outst = m_req && !up_ack;
      if (up_ack && !a) m_ovf = 1;
      if (a) begin
        sb.push_back(up_din);
        m_cin++;
      end
      if (p) m_cout++;
      m_cnt = m_cnt + int'(a) - int'(p);
      m_ack = p;
      m_req = (DEPTH - m_cnt) > int'(outst);
    end
  end

  // monitor: pops the scoreboard on every delivered token
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (dn_ack) begin
        if (sb.size() == 0) chk("dn_unexpected", 1, 0);
        else chk("dn_dout", dn_dout, sb.pop_front());
      end
      chk("dn_ack", 32'(dn_ack), 32'(m_ack));
      chk("level", 32'(level), m_cnt);
      chk("up_req", 32'(up_req), 32'(m_req));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("count_in", count_in, m_cin);
      chk("count_out", count_out, m_cout);
    end
  end

  // automatic producer / consumer stimulus
  bit auto_on  = 0;
  bit prod_en  = 0;
  bit pulse    = 0;
  int rate     = 100;
  int dn_rate  = 0;
  int next_tok = 0;
  int tok_lim  = 0;

  task automatic cycle();
    bit a;
    @(posedge clk); #1;
    if (auto_on) begin
      a = prod_en && up_req && (next_tok < tok_lim) &&
          !(pulse && up_ack) && ($urandom_range(99) < rate);
      up_ack = a;
      if (a) begin
        up_din = next_tok;
        next_tok++;
      end
      dn_req = ($urandom_range(99) < dn_rate);
    end
  endtask

  task automatic drive(bit a, logic [DW-1:0] d, bit r);
    @(posedge clk); #1;
    up_ack = a;
    up_din = d;
    dn_req = r;
  endtask

  task automatic do_reset();
    auto_on = 0;
    up_ack = 0;
    dn_req = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst = 0;
    chk("rst_level", 32'(level), 0);
    chk("rst_up_req", 32'(up_req), 0);
    chk("rst_dn_ack", 32'(dn_ack), 0);
    chk("rst_dout", dn_dout, 0);
    @(posedge clk); #1;
    chk("first_up_req", 32'(up_req), 1);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int ci;
    int maxlvl;
    int target;
    bit seen;
    logic [DW-1:0] first;

    do_reset();

    // fill 0..3 with no downstream demand
    next_tok = 0; tok_lim = 4;
    prod_en = 1; pulse = 0; rate = 100; dn_rate = 0;
    auto_on = 1;
    run(8);
    chk("fill_level", 32'(level), DEPTH);
    chk("fill_up_req", 32'(up_req), 0);
    chk("fill_cin", count_in, 4);
    chk("fill_ovf", 32'(overflow), 0);

    // drain 0..3, one ack per two cycles
    prod_en = 0; dn_rate = 100;
    run(12);
    chk("drain_level", 32'(level), 0);
    chk("drain_cout", count_out, 4);

    // 5000 tokens, pulsed producer, continuous demand
    prod_en = 1; pulse = 1; rate = 100;
    tok_lim = next_tok + 5000;
    target = tok_lim;
    maxlvl = 0;
    for (int i = 0; i < 30000 && int'(count_out) < target; i++) begin
      cycle();
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    chk("stream_done", count_out, target);
    chk("stream_max_le2", 32'(maxlvl <= 2), 1);
    chk("stream_ovf", 32'(overflow), 0);

    // fill again, then simultaneous push/pop at full
    prod_en = 1; pulse = 0; dn_rate = 0;
    tok_lim = next_tok + DEPTH;
    run(10);
    chk("full2_level", 32'(level), DEPTH);
    auto_on = 0;
    ci = int'(count_in);
    drive(1, 32'hCAFE0001, 1);
    drive(0, 0, 0);
    chk("simul_level", 32'(level), DEPTH);
    chk("simul_cin", count_in, ci + 1);

    // non-compliant acks while full
    ci = int'(count_in);
    drive(1, 32'hBAD0, 0);
    drive(1, 32'hBAD1, 0);
    drive(1, 32'hBAD2, 0);
    drive(0, 0, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), DEPTH);
    chk("ovf_cin", count_in, ci);
    drive(0, 0, 1);
    repeat (12) drive(0, 0, 1);
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_drained", 32'(level), 0);

    // random mix of compliant traffic
    auto_on = 1;
    prod_en = 1;
    tok_lim = 32'h7fff_0000;
    for (int k = 0; k < 30; k++) begin
      pulse = 1'($urandom_range(1));
      rate = $urandom_range(100);
      dn_rate = $urandom_range(100);
      run(100);
    end
    prod_en = 0; dn_rate = 100;
    run(20);
    chk("rand_drained", 32'(level), 0);

    // async reset mid-cycle with three tokens held
    do_reset();
    prod_en = 1; pulse = 0; rate = 100; dn_rate = 0;
    tok_lim = next_tok + 3;
    auto_on = 1;
    run(8);
    chk("pre_rst_level", 32'(level), 3);
    auto_on = 0;
    @(negedge clk); #2;
    rst = 1;
    #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_dn_ack", 32'(dn_ack), 0);
    chk("arst_up_req", 32'(up_req), 0);
    chk("arst_cin", count_in, 0);
    chk("arst_cout", count_out, 0);
    @(posedge clk);
    @(negedge clk); #3;
    up_ack = 0; dn_req = 0;
    rst = 0;
    tok_lim = next_tok + 1;
    first = next_tok;
    prod_en = 1; dn_rate = 100;
    auto_on = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (dn_ack) seen = 1;
    end
    chk("post_rst_seen", 32'(seen), 1);
    chk("post_rst_tok", dn_dout, first);
    chk("post_rst_cout", count_out, 1);
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
